fb_rect_fill: RTL and testbench
===============================

Name: fb_rect_fill

Overview:
- Hardware rectangle-fill engine: the write-side counterpart of the VGA controller's frame-buffer read on port B.
- Writes a solid 12-bit colour into a clipped rectangle of the 320x240 frame buffer through frame-buffer port A.
- Port A access is gated by a grant from memory_io, which owns port A arbitration.
- Commands come from SFR outputs of the core; the engine can optionally hold off until the next vblank_int pulse.

Parameters:
- FB_WIDTH, 320, pixels per row; also the row address stride.
- FB_HEIGHT, 240, number of rows.
- ADDR_W, 17, frame-buffer address width.
- PIX_W, 12, pixel width (RGB 4:4:4).
- COORD_W, 9, width of coordinate and size operands.

Ports:
- clock  in  1  core clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- vsync_mode  in  1  latched with start; 1 = wait for vblank before filling.
- x0  in  COORD_W  left column.
- y0  in  COORD_W  top row.
- width  in  COORD_W  rectangle width in pixels.
- height  in  COORD_W  rectangle height in pixels.
- color  in  PIX_W  fill colour.
- abort  in  1  cancel the current command.
- vblank_int  in  1  one-cycle vblank pulse, already in the clock domain.
- fb_gnt  in  1  port A granted this cycle.
- fb_req  out  1  engine wants port A.
- fb_wen  out  1  write enable to frame buffer port A.
- fb_addr  out  ADDR_W  write address.
- fb_din  out  PIX_W  write data.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal registers 0.
- States: IDLE, WAIT_VB, FILL, DONE.
- IDLE:
  - start=1 and abort=0 latches x0, y0, color and vsync_mode, and computes the clipped size.
  - Next state: DONE if the clipped area is empty; else WAIT_VB if vsync_mode=1; else FILL.
  - busy rises on the cycle after start.
  - start and abort both high in IDLE: abort wins, command ignored.
- Clipping:
  - Area is empty if x0>=FB_WIDTH, y0>=FB_HEIGHT, width=0 or height=0.
  - eff_w = min(width, FB_WIDTH-x0); eff_h = min(height, FB_HEIGHT-y0).
  - Compares are done at COORD_W+1 bits so FB_WIDTH-x0 never wraps.
- WAIT_VB:
  - Stays until vblank_int=1, then FILL next cycle.
  - A vblank_int pulse on the same cycle as start is not counted.
- FILL:
  - fb_req=1 throughout.
  - fb_wen = fb_req & fb_gnt (combinational from the state register and fb_gnt).
  - fb_addr and fb_din are registers. fb_addr starts at y0*FB_WIDTH+x0, computed once on entry by shift-add; no runtime multiplier in the loop.
  - Each granted cycle advances the column counter and fb_addr by 1.
  - At the last column: column counter clears, row counter increments, and row_base += FB_WIDTH. fb_addr becomes the new row_base + x0.
  - Grant low: no write, counters and fb_addr hold. Any grant pattern yields exactly eff_w*eff_h writes.
  - The granted write of the last pixel (row eff_h-1, column eff_w-1) goes to DONE.
  - Addresses stay <= FB_WIDTH*FB_HEIGHT-1 by construction.
- DONE: done=1 for exactly one cycle, then IDLE. busy is 0 from the cycle after done.
- abort in WAIT_VB, FILL or DONE:
  - Next state IDLE with fb_req and fb_wen low from the next cycle.
  - No done pulse; a write in the abort cycle itself completes if granted.
- start while busy: ignored, no queuing.
- Reset mid-operation: immediate return to IDLE, all outputs low; frame-buffer contents unspecified.
- Throughput: 1 pixel/cycle with continuous grant; command latency = start + 2 setup cycles + eff_w*eff_h + 1 done cycle.

Decomposition:
- Shared package holds:
  - FB_WIDTH, FB_HEIGHT, ADDR_W, PIX_W, COORD_W, which are also used by the VGA controller and memory_io.
  - State encoding localparams IDLE=2'd0, WAIT_VB=2'd1, FILL=2'd2, DONE=2'd3.
- One natural sub-module, fb_rect_addr_gen: column/row counters, row_base accumulation and last-pixel flag, with advance, load and clear inputs.
- The FSM, clipping and handshake stay in fb_rect_fill.

Test Plan:
- Basic fill: x0=10, y0=5, w=4, h=3, color=12'hF00, vsync_mode=0, fb_gnt=1.
  - Required: 12 writes to addresses 1610-1613, 1930-1933 and 2250-2253, all data F00.
  - done pulses once, 1 cycle after the last write.
- Clip: x0=318, y0=238, w=5, h=5.
  - Required: 4 writes at 76478, 76479, 76798, 76799; no address >76799.
- Empty: w=0 (and separately x0=320).
  - Required: zero writes; done pulses 2 cycles after start; fb_req never high.
- Grant stall: w=3, h=2, fb_gnt toggling 1,0,1,0,...
  - Required: exactly 6 writes, same address sequence as with constant grant; fb_addr holds during gnt=0.
- vblank sync: vsync_mode=1; vblank_int pulsed 50 cycles after start.
  - Required: no fb_req before the pulse; first write 1 cycle after it.
- Abort and reset: abort after 7 of 20 writes.
  - Required: no further writes, no done pulse; busy low next cycle.
  - A new start then completes normally.
  - Reset asserted mid-FILL clears all outputs asynchronously.

Source files
------------

// File: rtl/fb_rect_fill_pkg.sv
// Shared frame-buffer geometry and rectangle-fill state encoding.
// Also used by the VGA controller and memory_io.
package fb_rect_fill_pkg;

  localparam int unsigned FB_WIDTH  = 320;
  localparam int unsigned FB_HEIGHT = 240;
  localparam int unsigned ADDR_W    = 17;
  localparam int unsigned PIX_W     = 12;
  localparam int unsigned COORD_W   = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VB = 2'd1,
    FILL    = 2'd2,
    DONE    = 2'd3
  } state_e;

  // y * FB_WIDTH as shift-add; the shifts must track FB_WIDTH (320 = 256 + 64).
  function automatic logic [ADDR_W-1:0] row_offset(input logic [COORD_W-1:0] y);
    logic [ADDR_W-1:0] yy;
    yy = ADDR_W'(y);
    return (yy << 8) + (yy << 6);
  endfunction

endpackage

// File: rtl/fb_rect_addr_gen.sv
// Column/row walker for the rectangle fill: produces the write address and last-pixel flag.
// load computes the row base; the first pixel address follows one cycle later.
module fb_rect_addr_gen
  import fb_rect_fill_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               load,
  input  logic               advance,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] eff_w,
  input  logic [COORD_W-1:0] eff_h,
  output logic [ADDR_W-1:0]  addr,
  output logic               last
);

  logic [COORD_W-1:0] col_q;
  logic [COORD_W-1:0] row_q;
  logic [ADDR_W-1:0]  row_base_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               seed_q;
  logic               col_end;

  assign col_end = (col_q == eff_w - COORD_W'(1));
  assign last    = col_end && (row_q == eff_h - COORD_W'(1));
  assign addr    = addr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      seed_q     <= 1'b0;
    end else if (clear) begin
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      seed_q     <= 1'b0;
    end else if (load) begin
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= row_offset(y0);
      seed_q     <= 1'b1;
    end else if (seed_q) begin
      addr_q <= row_base_q + ADDR_W'(x0);
      seed_q <= 1'b0;
    end else if (advance && !last) begin
      // Holding on the last pixel keeps fb_addr inside the frame buffer.
      if (col_end) begin
        col_q      <= '0;
        row_q      <= row_q + COORD_W'(1);
        row_base_q <= row_base_q + ADDR_W'(FB_WIDTH);
        addr_q     <= row_base_q + ADDR_W'(FB_WIDTH) + ADDR_W'(x0);
      end else begin
        col_q  <= col_q + COORD_W'(1);
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle-fill engine: clips a command to the frame buffer and writes a solid colour
// through frame-buffer port A under memory_io's grant, optionally synchronised to vblank.
module fb_rect_fill
  import fb_rect_fill_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               vsync_mode,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] width,
  input  logic [COORD_W-1:0] height,
  input  logic [PIX_W-1:0]   color,
  input  logic               abort,
  input  logic               vblank_int,
  input  logic               fb_gnt,
  output logic               fb_req,
  output logic               fb_wen,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [PIX_W-1:0]   fb_din,
  output logic               busy,
  output logic               done
);

  localparam logic [COORD_W:0] FB_W_EXT = (COORD_W+1)'(FB_WIDTH);
  localparam logic [COORD_W:0] FB_H_EXT = (COORD_W+1)'(FB_HEIGHT);

  state_e             state_q;
  logic               busy_q;
  logic               done_q;
  logic               fb_req_q;
  logic [PIX_W-1:0]   fb_din_q;
  logic [COORD_W-1:0] x0_q;
  logic [COORD_W-1:0] y0_q;
  logic [COORD_W-1:0] eff_w_q;
  logic [COORD_W-1:0] eff_h_q;
  logic               vsync_q;
  logic               empty_q;
  logic               prime_q;

  logic [COORD_W:0]   span_w;
  logic [COORD_W:0]   span_h;
  logic [COORD_W-1:0] eff_w_c;
  logic [COORD_W-1:0] eff_h_c;
  logic               empty_c;
  logic               gen_load;
  logic               gen_clear;
  logic               gen_last;

  // Extra bit keeps FB_WIDTH - x0 from wrapping; the empty flag covers x0 >= FB_WIDTH.
  always_comb begin
    span_w  = FB_W_EXT - {1'b0, x0};
    span_h  = FB_H_EXT - {1'b0, y0};
    eff_w_c = ({1'b0, width} < span_w) ? width : span_w[COORD_W-1:0];
    eff_h_c = ({1'b0, height} < span_h) ? height : span_h[COORD_W-1:0];
    empty_c = ({1'b0, x0} >= FB_W_EXT) || ({1'b0, y0} >= FB_H_EXT) ||
              (width == '0) || (height == '0);
  end

  // Busy while IDLE marks the two setup cycles: row base, then first address.
  assign gen_load  = (state_q == IDLE) && busy_q && !prime_q && !abort;
  assign gen_clear = abort && busy_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fb_req_q <= 1'b0;
      fb_din_q <= '0;
      x0_q     <= '0;
      y0_q     <= '0;
      eff_w_q  <= '0;
      eff_h_q  <= '0;
      vsync_q  <= 1'b0;
      empty_q  <= 1'b0;
      prime_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!busy_q) begin
            if (start && !abort) begin
              x0_q     <= x0;
              y0_q     <= y0;
              fb_din_q <= color;
              vsync_q  <= vsync_mode;
              eff_w_q  <= eff_w_c;
              eff_h_q  <= eff_h_c;
              empty_q  <= empty_c;
              prime_q  <= 1'b0;
              busy_q   <= 1'b1;
            end
          end else if (abort) begin
            busy_q  <= 1'b0;
            prime_q <= 1'b0;
          end else if (!prime_q) begin
            if (empty_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              prime_q <= 1'b1;
            end
          end else begin
            prime_q  <= 1'b0;
            fb_req_q <= !vsync_q;
            state_q  <= vsync_q ? WAIT_VB : FILL;
          end
        end
        WAIT_VB: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (vblank_int) begin
            state_q  <= FILL;
            fb_req_q <= 1'b1;
          end
        end
        FILL: begin
          if (abort) begin
            state_q  <= IDLE;
            fb_req_q <= 1'b0;
            busy_q   <= 1'b0;
          end else if (fb_gnt && gen_last) begin
            state_q  <= DONE;
            fb_req_q <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  fb_rect_addr_gen u_addr_gen (
    .clock   (clock),
    .reset   (reset),
    .clear   (gen_clear),
    .load    (gen_load),
    .advance (fb_wen),
    .x0      (x0_q),
    .y0      (y0_q),
    .eff_w   (eff_w_q),
    .eff_h   (eff_h_q),
    .addr    (fb_addr),
    .last    (gen_last)
  );

  assign fb_req = fb_req_q;
  assign fb_wen = fb_req_q & fb_gnt;
  assign fb_din = fb_din_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Self-checking bench for fb_rect_fill: randomized rectangles against a nested-loop
// pixel model, plus directed clip, empty, stall, vblank, abort and reset scenarios.
module tb_fb_rect_fill;
  import fb_rect_fill_pkg::*;

  logic               clock = 1'b0;
  logic               reset, start, vsync_mode, abort, vblank_int, fb_gnt;
  logic [COORD_W-1:0] x0, y0, width, height;
  logic [PIX_W-1:0]   color;
  logic               fb_req, fb_wen, busy, done;
  logic [ADDR_W-1:0]  fb_addr;
  logic [PIX_W-1:0]   fb_din;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int gnt_mode = 0;
  int wr_addr[$], wr_data[$], wr_cyc[$], exp_addr[$];
  int done_cnt, done_cyc, first_req_cyc, hold_viol, max_addr, start_cyc;
  int prev_addr;
  bit prev_stall;

  fb_rect_fill dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .vsync_mode (vsync_mode),
    .x0         (x0),
    .y0         (y0),
    .width      (width),
    .height     (height),
    .color      (color),
    .abort      (abort),
    .vblank_int (vblank_int),
    .fb_gnt     (fb_gnt),
    .fb_req     (fb_req),
    .fb_wen     (fb_wen),
    .fb_addr    (fb_addr),
    .fb_din     (fb_din),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset) begin
      if (fb_wen) begin
        wr_addr.push_back(int'(fb_addr));
        wr_data.push_back(int'(fb_din));
        wr_cyc.push_back(cyc);
        if (int'(fb_addr) > max_addr) max_addr = int'(fb_addr);
      end
      if (prev_stall && fb_req && int'(fb_addr) != prev_addr) hold_viol++;
      prev_stall = fb_req && !fb_gnt;
      prev_addr  = int'(fb_addr);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (fb_req && first_req_cyc < 0) first_req_cyc = cyc;
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
    case (gnt_mode)
      0:       fb_gnt = 1'b1;
      1:       fb_gnt = ~fb_gnt;
      default: fb_gnt = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Reference: every in-frame pixel of the rectangle, row-major.
  task automatic build_model(input int x, input int y, input int w, input int h);
    int ew, eh;
    exp_addr.delete();
    if (x >= int'(FB_WIDTH) || y >= int'(FB_HEIGHT) || w == 0 || h == 0) return;
    ew = (w < int'(FB_WIDTH) - x) ? w : int'(FB_WIDTH) - x;
    eh = (h < int'(FB_HEIGHT) - y) ? h : int'(FB_HEIGHT) - y;
    for (int r = 0; r < eh; r++)
      for (int c = 0; c < ew; c++)
        exp_addr.push_back((y + r) * int'(FB_WIDTH) + x + c);
  endtask

  task automatic launch(input int x, input int y, input int w, input int h, input int col,
                        input bit vs);
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    done_cnt = 0; done_cyc = -1; first_req_cyc = -1; hold_viol = 0; max_addr = 0;
    prev_stall = 0;
    x0 = COORD_W'(x); y0 = COORD_W'(y); width = COORD_W'(w); height = COORD_W'(h);
    color = PIX_W'(col); vsync_mode = vs; start = 1'b1; start_cyc = cyc;
    vblank_int = vs;  // coincident pulse must be ignored
    tick;
    start = 1'b0; vblank_int = 1'b0;
    x0 = COORD_W'($urandom); y0 = COORD_W'($urandom);
    width = COORD_W'($urandom); height = COORD_W'($urandom);
    color = PIX_W'($urandom); vsync_mode = 1'($urandom);
  endtask

  task automatic run_cmd(input int x, input int y, input int w, input int h, input int col,
                         input bit vs, input int vb_delay, input int restart_at,
                         output bit timed_out);
    launch(x, y, w, h, col, vs);
    timed_out = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      vblank_int = vs && (cyc - start_cyc == vb_delay);
      start = (restart_at > 0) && (cyc - start_cyc == restart_at);
      tick;
      if (done_cnt > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    vblank_int = 1'b0; start = 1'b0;
    repeat (3) tick;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 0; abort = 0; vblank_int = 0; fb_gnt = 1; vsync_mode = 0;
    x0 = 0; y0 = 0; width = 0; height = 0; color = 0;
    repeat (3) tick;
    checks++; if (fb_req !== 1'b0) $display("FAIL reset_req: got %b want 0", fb_req); else passes++;
    checks++; if (fb_wen !== 1'b0) $display("FAIL reset_wen: got %b want 0", fb_wen); else passes++;
    checks++; if (fb_addr !== '0) $display("FAIL reset_addr: got %0d want 0", fb_addr); else passes++;
    checks++; if (fb_din !== '0) $display("FAIL reset_din: got %h want 0", fb_din); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passes++;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    bit to;
    int mism;
    gnt_mode = 0;
    run_cmd(10, 5, 4, 3, 'hF00, 1'b0, 0, 0, to);
    build_model(10, 5, 4, 3);
    mism = 0;
    for (int i = 0; i < exp_addr.size(); i++)
      if (i >= wr_addr.size() || wr_addr[i] != exp_addr[i] || wr_data[i] != 'hF00) mism++;
    checks++; if (to) $display("FAIL basic_timeout: got no done want done"); else passes++;
    checks++; if (wr_addr.size() != 12) $display("FAIL basic_count: got %0d want 12", wr_addr.size()); else passes++;
    checks++; if (mism != 0) $display("FAIL basic_seq: got %0d bad pixels want 0", mism); else passes++;
    checks++; if (done_cnt != 1) $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); else passes++;
    checks++; if (done_cyc != wr_cyc[$] + 1) $display("FAIL basic_done_cyc: got %0d want %0d", done_cyc, wr_cyc[$] + 1); else passes++;
    checks++; if (wr_cyc[0] != start_cyc + 3) $display("FAIL basic_latency: got %0d want %0d", wr_cyc[0], start_cyc + 3); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy_after: got %b want 0", busy); else passes++;
  endtask

  task automatic test_clip;
    bit to;
    int mism;
    gnt_mode = 0;
    run_cmd(318, 238, 5, 5, 'h0AB, 1'b0, 0, 0, to);
    build_model(318, 238, 5, 5);
    mism = 0;
    for (int i = 0; i < exp_addr.size(); i++)
      if (i >= wr_addr.size() || wr_addr[i] != exp_addr[i]) mism++;
    checks++; if (wr_addr.size() != 4) $display("FAIL clip_count: got %0d want 4", wr_addr.size()); else passes++;
    checks++; if (mism != 0) $display("FAIL clip_seq: got %0d bad pixels want 0", mism); else passes++;
    checks++; if (max_addr > 76799) $display("FAIL clip_max_addr: got %0d want <=76799", max_addr); else passes++;
    checks++; if (done_cnt != 1 || to) $display("FAIL clip_done: got %0d want 1", done_cnt); else passes++;
  endtask

  task automatic test_empty;
    bit to;
    int xs[2];
    int ws[2];
    xs = '{10, 320};
    ws = '{0, 6};
    gnt_mode = 0;
    for (int k = 0; k < 2; k++) begin
      run_cmd(xs[k], 4, ws[k], 3, 'h123, 1'b0, 0, 0, to);
      checks++; if (wr_addr.size() != 0) $display("FAIL empty_writes[%0d]: got %0d want 0", k, wr_addr.size()); else passes++;
      checks++; if (done_cyc != start_cyc + 2) $display("FAIL empty_done_cyc[%0d]: got %0d want %0d", k, done_cyc, start_cyc + 2); else passes++;
      checks++; if (first_req_cyc != -1) $display("FAIL empty_req[%0d]: got req at %0d want never", k, first_req_cyc); else passes++;
    end
  endtask

  task automatic test_grant_stall;
    bit to;
    int mism;
    gnt_mode = 1;
    run_cmd(100, 50, 3, 2, 'h555, 1'b0, 0, 0, to);
    build_model(100, 50, 3, 2);
    mism = 0;
    for (int i = 0; i < exp_addr.size(); i++)
      if (i >= wr_addr.size() || wr_addr[i] != exp_addr[i]) mism++;
    checks++; if (wr_addr.size() != 6) $display("FAIL stall_count: got %0d want 6", wr_addr.size()); else passes++;
    checks++; if (mism != 0) $display("FAIL stall_seq: got %0d bad pixels want 0", mism); else passes++;
    checks++; if (hold_viol != 0) $display("FAIL stall_hold: got %0d moves want 0", hold_viol); else passes++;
    gnt_mode = 0;
  endtask

  task automatic test_vblank;
    bit to;
    int mism;
    gnt_mode = 0;
    run_cmd(20, 30, 6, 2, 'h0F0, 1'b1, 50, 0, to);
    build_model(20, 30, 6, 2);
    mism = 0;
    for (int i = 0; i < exp_addr.size(); i++)
      if (i >= wr_addr.size() || wr_addr[i] != exp_addr[i]) mism++;
    checks++; if (first_req_cyc != start_cyc + 51) $display("FAIL vb_req: got %0d want %0d", first_req_cyc, start_cyc + 51); else passes++;
    checks++; if (wr_cyc.size() == 0 || wr_cyc[0] != start_cyc + 51) $display("FAIL vb_first_write: got %0d want %0d", wr_cyc.size() ? wr_cyc[0] : -1, start_cyc + 51); else passes++;
    checks++; if (mism != 0 || wr_addr.size() != 12) $display("FAIL vb_seq: got %0d writes want 12", wr_addr.size()); else passes++;
  endtask

  task automatic test_busy_start;
    bit to;
    int mism;
    gnt_mode = 0;
    run_cmd(60, 70, 8, 3, 'h3C3, 1'b0, 0, 6, to);
    build_model(60, 70, 8, 3);
    mism = 0;
    for (int i = 0; i < exp_addr.size(); i++)
      if (i >= wr_addr.size() || wr_addr[i] != exp_addr[i] || wr_data[i] != 'h3C3) mism++;
    checks++; if (mism != 0 || wr_addr.size() != 24) $display("FAIL busy_start_seq: got %0d writes want 24", wr_addr.size()); else passes++;
    checks++; if (done_cnt != 1) $display("FAIL busy_start_done: got %0d want 1", done_cnt); else passes++;
  endtask

  task automatic test_random;
    bit to;
    int mism, x, y, w, h, col;
    bit vs;
    for (int n = 0; n < 8; n++) begin
      x = $urandom_range(0, 330); y = $urandom_range(0, 250);
      w = $urandom_range(0, 20);  h = $urandom_range(0, 20);
      if (n < 2) begin x = $urandom_range(305, 319); y = $urandom_range(225, 239); end
      col = $urandom_range(0, 4095); vs = 1'($urandom);
      gnt_mode = $urandom_range(0, 2);
      run_cmd(x, y, w, h, col, vs, $urandom_range(10, 30), 0, to);
      build_model(x, y, w, h);
      mism = 0;
      for (int i = 0; i < exp_addr.size(); i++)
        if (i >= wr_addr.size() || wr_addr[i] != exp_addr[i] || wr_data[i] != col) mism++;
      checks++; if (to || done_cnt != 1) $display("FAIL rand_done[%0d]: got %0d want 1", n, done_cnt); else passes++;
      checks++; if (wr_addr.size() != exp_addr.size() || mism != 0) $display("FAIL rand_seq[%0d]: got %0d writes (%0d bad) want %0d", n, wr_addr.size(), mism, exp_addr.size()); else passes++;
      if (exp_addr.size() == 0) begin
        checks++; if (done_cyc != start_cyc + 2) $display("FAIL rand_empty_cyc[%0d]: got %0d want %0d", n, done_cyc, start_cyc + 2); else passes++;
      end
    end
    gnt_mode = 0;
  endtask

  task automatic test_abort;
    bit to, busy_after, req_after;
    int mism;
    gnt_mode = 0;
    build_model(40, 100, 5, 4);
    launch(40, 100, 5, 4, 'hABC, 1'b0);
    for (int i = 0; i < 200; i++) begin
      if (wr_addr.size() == 6) begin
        abort = 1'b1;  // this cycle carries the 7th write
        tick;
        break;
      end
      tick;
    end
    abort = 1'b0;
    @(negedge clock);
    busy_after = busy; req_after = fb_req;
    repeat (30) tick;
    mism = 0;
    for (int i = 0; i < wr_addr.size(); i++) if (wr_addr[i] != exp_addr[i]) mism++;
    checks++; if (wr_addr.size() != 7 || mism != 0) $display("FAIL abort_writes: got %0d (%0d bad) want 7", wr_addr.size(), mism); else passes++;
    checks++; if (done_cnt != 0) $display("FAIL abort_done: got %0d want 0", done_cnt); else passes++;
    checks++; if (busy_after !== 1'b0 || req_after !== 1'b0) $display("FAIL abort_busy: got busy=%b req=%b want 0 0", busy_after, req_after); else passes++;
    run_cmd(3, 7, 8, 3, 'h777, 1'b0, 0, 0, to);
    build_model(3, 7, 8, 3);
    mism = 0;
    for (int i = 0; i < exp_addr.size(); i++)
      if (i >= wr_addr.size() || wr_addr[i] != exp_addr[i]) mism++;
    checks++; if (to || done_cnt != 1 || mism != 0 || wr_addr.size() != 24) $display("FAIL abort_restart: got %0d writes done=%0d want 24 1", wr_addr.size(), done_cnt); else passes++;
  endtask

  task automatic test_reset_mid;
    bit to;
    int mism;
    gnt_mode = 0;
    launch(0, 0, 30, 10, 'hFFF, 1'b0);
    repeat (20) tick;
    checks++; if (fb_req !== 1'b1) $display("FAIL rst_mid_active: got req=%b want 1", fb_req); else passes++;
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({fb_req, fb_wen, busy, done, fb_addr, fb_din} !== '0) $display("FAIL rst_mid_clear: got req=%b wen=%b busy=%b done=%b addr=%0d din=%h want all 0", fb_req, fb_wen, busy, done, fb_addr, fb_din); else passes++;
    repeat (2) tick;
    reset = 1'b0;
    tick;
    run_cmd(200, 200, 4, 4, 'h0C0, 1'b0, 0, 0, to);
    build_model(200, 200, 4, 4);
    mism = 0;
    for (int i = 0; i < exp_addr.size(); i++)
      if (i >= wr_addr.size() || wr_addr[i] != exp_addr[i]) mism++;
    checks++; if (to || mism != 0 || wr_addr.size() != 16) $display("FAIL rst_mid_after: got %0d writes want 16", wr_addr.size()); else passes++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_clip;
    test_empty;
    test_grant_stall;
    test_vblank;
    test_busy_start;
    test_random;
    test_abort;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
